// File: rtl/s2p_symbol_packer.sv
// s2p_symbol_packer: packs a serial bit stream, one bit per enabled cycle,
// into symbols of 1, 2, 4 or 6 bits. The width is chosen by mode and is
// latched at each symbol boundary. A one-cycle strobe marks each finished
// symbol. sync_clr drops a partial symbol so the packer can realign.
module s2p_symbol_packer #(
  parameter int MAX_BITS  = 6,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          mode,
  input  logic                bit_valid,
  input  logic                bit_in,
  input  logic                sync_clr,
  output logic [MAX_BITS-1:0] sym_data,
  output logic                sym_valid,
  output logic [2:0]          sym_bits,
  output logic [2:0]          bits_held
);

  // Symbol assembly state
  logic [MAX_BITS-1:0] r_sr;
  logic [2:0]          r_cnt;
  logic [2:0]          r_kAct;

  // Output registers
  logic [MAX_BITS-1:0] r_symData;
  logic                r_symValid;
  logic [2:0]          r_symBits;

  // Next-state helpers
  logic [2:0]          w_kMode;
  logic [2:0]          w_cntBase;
  logic [MAX_BITS-1:0] w_srBase;
  logic [2:0]          w_kEff;
  logic                w_complete;
  logic [MAX_BITS-1:0] w_srNext;

  // Decode mode into bits per symbol
  function automatic logic [2:0] kOfMode(input logic [1:0] m);
    case (m)
      2'b00:   kOfMode = 3'd1;
      2'b01:   kOfMode = 3'd2;
      2'b10:   kOfMode = 3'd4;
      default: kOfMode = 3'd6;
    endcase
  endfunction

  // Work out where this cycle's bit lands and whether it closes a symbol.
  // sync_clr acts as if the packer were already empty. A bit arriving in the
  // same cycle therefore starts a fresh symbol that uses the current mode.
  always_comb begin
    w_kMode   = kOfMode(mode);
    w_cntBase = sync_clr ? 3'd0 : r_cnt;
    w_srBase  = sync_clr ? '0 : r_sr;
    w_kEff    = (w_cntBase == 3'd0) ? w_kMode : r_kAct;
    w_complete = (w_cntBase == (w_kEff - 3'd1));
    w_srNext  = w_srBase;
    if (MSB_FIRST) begin
      w_srNext = {w_srBase[MAX_BITS-2:0], bit_in};
    end else begin
      for (int i = 0; i < MAX_BITS; i++) begin
        if (i == int'(w_cntBase)) begin
          w_srNext[i] = bit_in;
        end
      end
    end
  end

  // Shift register, bit counter and latched width. The shift register is
  // cleared whenever a symbol completes. Because of that, only the new
  // symbol's bits are ever non-zero, and the unused upper bits read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr   <= '0;
      r_cnt  <= 3'd0;
      r_kAct <= 3'd1;
    end else begin
      r_kAct <= w_kEff;
      if (bit_valid) begin
        if (w_complete) begin
          r_sr  <= '0;
          r_cnt <= 3'd0;
        end else begin
          r_sr  <= w_srNext;
          r_cnt <= w_cntBase + 3'd1;
        end
      end else begin
        r_sr  <= w_srBase;
        r_cnt <= w_cntBase;
      end
    end
  end

  // Load the completed symbol and raise the strobe for exactly one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_symData  <= '0;
      r_symValid <= 1'b0;
      r_symBits  <= 3'd1;
    end else begin
      r_symValid <= bit_valid && w_complete;
      if (bit_valid && w_complete) begin
        r_symData <= w_srNext;
        r_symBits <= w_kEff;
      end
    end
  end

  assign sym_data  = r_symData;
  assign sym_valid = r_symValid;
  assign sym_bits  = r_symBits;
  assign bits_held = r_cnt;

endmodule

// File: tb/tb_s2p_symbol_packer.sv
// tb_s2p_symbol_packer: directed vectors with hand-computed symbols.
// Two instances share every input, one MSB-first and one LSB-first.
module tb_s2p_symbol_packer;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic [1:0] mode = 2'b01;
  logic       bitValid = 1'b0;
  logic       bitIn = 1'b0;
  logic       syncClr = 1'b0;

  logic [5:0] symDataM, symDataL;
  logic       symValidM, symValidL;
  logic [2:0] symBitsM, symBitsL;
  logic [2:0] bitsHeldM, bitsHeldL;

  int compareCount = 0;
  int mismatchCount = 0;

  logic [7:0] bpskBits;

  s2p_symbol_packer #(.MAX_BITS(6), .MSB_FIRST(1'b1)) dutMsb (
    .clk(clk), .rst_n(rstN), .mode(mode), .bit_valid(bitValid),
    .bit_in(bitIn), .sync_clr(syncClr), .sym_data(symDataM),
    .sym_valid(symValidM), .sym_bits(symBitsM), .bits_held(bitsHeldM)
  );

  s2p_symbol_packer #(.MAX_BITS(6), .MSB_FIRST(1'b0)) dutLsb (
    .clk(clk), .rst_n(rstN), .mode(mode), .bit_valid(bitValid),
    .bit_in(bitIn), .sync_clr(syncClr), .sym_data(symDataL),
    .sym_valid(symValidL), .sym_bits(symBitsL), .bits_held(bitsHeldL)
  );

  // Free-running system clock
  always #5 clk = ~clk;

  // Count one comparison and report it if it differs
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then return 1 ns after the capturing edge
  task automatic applyStimulus(input logic valid, input logic b, input logic clr);
    bitValid = valid;
    bitIn    = b;
    syncClr  = clr;
    @(posedge clk);
    #1;
    bitValid = 1'b0;
    syncClr  = 1'b0;
  endtask

  // Stimulus sequence with expected values worked out by hand
  initial begin
    #12;
    checkOutput("rst_data", symDataM, 0);
    checkOutput("rst_valid", symValidM, 0);
    checkOutput("rst_bits", symBitsM, 1);
    checkOutput("rst_held", bitsHeldM, 0);
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk); #1;

    // QPSK: 1,0,1,1 -> 2'b10 then 2'b11
    mode = 2'b01;
    applyStimulus(1, 1, 0);
    checkOutput("qpsk_v1", symValidM, 0);
    checkOutput("qpsk_h1", bitsHeldM, 1);
    applyStimulus(1, 0, 0);
    checkOutput("qpsk_v2", symValidM, 1);
    checkOutput("qpsk_d2", symDataM, 2);
    checkOutput("qpsk_k2", symBitsM, 2);
    checkOutput("qpsk_h2", bitsHeldM, 0);
    applyStimulus(1, 1, 0);
    checkOutput("qpsk_v3", symValidM, 0);
    applyStimulus(1, 1, 0);
    checkOutput("qpsk_v4", symValidM, 1);
    checkOutput("qpsk_d4", symDataM, 3);
    applyStimulus(0, 0, 0);
    checkOutput("qpsk_idle_v", symValidM, 0);
    checkOutput("qpsk_idle_d", symDataM, 3);

    // 16-QAM with gaps: 1,1,0,1 -> 0xD
    mode = 2'b10;
    applyStimulus(1, 1, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(1, 1, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    checkOutput("q16_h3", bitsHeldM, 3);
    checkOutput("q16_v3", symValidM, 0);
    applyStimulus(0, 0, 0);
    checkOutput("q16_hold_h", bitsHeldM, 3);
    applyStimulus(1, 1, 0);
    checkOutput("q16_v4", symValidM, 1);
    checkOutput("q16_d4", symDataM, 'h0D);
    checkOutput("q16_k4", symBitsM, 4);
    applyStimulus(0, 0, 0);
    checkOutput("q16_strobe_end", symValidM, 0);

    // 64-QAM: 1,0,1,1,0,0 -> 0x2C MSB-first, 0x0D LSB-first
    mode = 2'b11;
    applyStimulus(1, 1, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 1, 0);
    applyStimulus(1, 1, 0);
    applyStimulus(1, 0, 0);
    checkOutput("q64_h5", bitsHeldM, 5);
    checkOutput("q64_v5", symValidM, 0);
    applyStimulus(1, 0, 0);
    checkOutput("q64_v6", symValidM, 1);
    checkOutput("q64_msb_d", symDataM, 'h2C);
    checkOutput("q64_k", symBitsM, 6);
    checkOutput("q64_lsb_v", symValidL, 1);
    checkOutput("q64_lsb_d", symDataL, 'h0D);

    // Mode change mid-symbol: the 4-bit symbol 1110 finishes, then QPSK 11
    mode = 2'b10;
    applyStimulus(1, 1, 0);
    applyStimulus(1, 1, 0);
    mode = 2'b01;
    applyStimulus(1, 1, 0);
    checkOutput("mchg_v3", symValidM, 0);
    checkOutput("mchg_h3", bitsHeldM, 3);
    applyStimulus(1, 0, 0);
    checkOutput("mchg_v4", symValidM, 1);
    checkOutput("mchg_d4", symDataM, 'h0E);
    checkOutput("mchg_k4", symBitsM, 4);
    applyStimulus(1, 1, 0);
    checkOutput("mchg_v5", symValidM, 0);
    applyStimulus(1, 1, 0);
    checkOutput("mchg_d6", symDataM, 3);
    checkOutput("mchg_k6", symBitsM, 2);

    // Realign: 1,1,1 discarded, sync_clr with 0, then 0,0,1 -> 0x01
    mode = 2'b10;
    applyStimulus(1, 1, 0);
    applyStimulus(1, 1, 0);
    applyStimulus(1, 1, 0);
    applyStimulus(1, 0, 1);
    checkOutput("sync_v", symValidM, 0);
    checkOutput("sync_h", bitsHeldM, 1);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    checkOutput("sync_v3", symValidM, 0);
    applyStimulus(1, 1, 0);
    checkOutput("sync_v4", symValidM, 1);
    checkOutput("sync_d4", symDataM, 1);

    // sync_clr on its own drops one held bit and leaves the outputs alone
    applyStimulus(1, 1, 0);
    applyStimulus(0, 0, 1);
    checkOutput("clr_h", bitsHeldM, 0);
    checkOutput("clr_v", symValidM, 0);
    checkOutput("clr_d", symDataM, 1);

    // BPSK continuous: 10110010, a strobe on every cycle
    mode = 2'b00;
    bpskBits = 8'b10110010;
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(1, bpskBits[i], 0);
      checkOutput($sformatf("bpsk_v%0d", i), symValidM, 1);
      checkOutput($sformatf("bpsk_d%0d", i), symDataM, {31'd0, bpskBits[i]});
      checkOutput($sformatf("bpsk_h%0d", i), bitsHeldM, 0);
    end
    checkOutput("bpsk_k", symBitsM, 1);
    checkOutput("bpsk_lsb_d", symDataL, 0);

    // sync_clr plus a bit with K=1 completes a symbol at once
    applyStimulus(1, 1, 1);
    checkOutput("syncK1_v", symValidM, 1);
    checkOutput("syncK1_d", symDataM, 1);

    // Asynchronous reset in the middle of a 64-QAM symbol
    mode = 2'b11;
    applyStimulus(1, 1, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 1, 0);
    checkOutput("prerst_h", bitsHeldM, 3);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("arst_d", symDataM, 0);
    checkOutput("arst_v", symValidM, 0);
    checkOutput("arst_k", symBitsM, 1);
    checkOutput("arst_h", bitsHeldM, 0);
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk); #1;
    // 0,1,1,0,1,0 -> 0x1A MSB-first, 0x16 LSB-first
    applyStimulus(1, 0, 0);
    applyStimulus(1, 1, 0);
    applyStimulus(1, 1, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 1, 0);
    checkOutput("post_h5", bitsHeldM, 5);
    applyStimulus(1, 0, 0);
    checkOutput("post_v", symValidM, 1);
    checkOutput("post_d", symDataM, 'h1A);
    checkOutput("post_k", symBitsM, 6);
    checkOutput("post_lsb_d", symDataL, 'h16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
